// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: iterative double-dabble, one input bit per clock.
// Optional build macro BIN2BCD_BLANK_EN blanks leading zero digits (4'hF) in the result.
module bin2bcd_seq #(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [63:0] calc_max_val();
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < DIGITS; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    // Largest value representable in DIGITS decimal digits, kept at 64 bits to avoid truncation.
    localparam logic [63:0] MAX_VAL = calc_max_val();

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t                state;
    logic [WIDTH-1:0]      shift_reg;
    logic [4*DIGITS-1:0]   scratch;
    logic [CW-1:0]         counter;
    logic                  ovf_pending;
    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   result;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
    end

    always_comb begin
`ifdef BIN2BCD_BLANK_EN
        logic leading;
        leading = 1'b1;
`endif
        result = scratch;
`ifdef BIN2BCD_BLANK_EN
        // Blank zeros above digit 0 until the first nonzero digit from the top.
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (leading && scratch[4*d +: 4] == 4'd0) result[4*d +: 4] = 4'hF;
            else leading = 1'b0;
        end
`endif
        if (ovf_pending) result = {DIGITS{4'h9}};
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift_reg   <= '0;
            scratch     <= '0;
            counter     <= '0;
            ovf_pending <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bcd         <= '0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg   <= bin;
                        scratch     <= '0;
                        counter     <= CW'(WIDTH);
                        ovf_pending <= (64'(bin) > MAX_VAL);
                        busy        <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Top scratch bit falls off: only DIGITS digits are kept.
                    {scratch, shift_reg} <= {adj[4*DIGITS-2:0], shift_reg, 1'b0};
                    counter <= counter - 1'b1;
                    if (counter == CW'(1)) state <= FINISH;
                end
                FINISH: begin
                    bcd      <= result;
                    overflow <= ovf_pending;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed boundaries, handshake, reset abort and random values
// compared against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 20;
    localparam int DIGITS = 6;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [WIDTH-1:0]    bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic                overflow;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: saturate above 999999, otherwise peel decimal digits with % and /.
    function automatic logic [24:0] model(input int unsigned v);
        logic [23:0] r;
        logic        ovf;
        int unsigned x;
        r   = '0;
        ovf = (v > 999999);
        if (ovf) begin
            r = 24'h999999;
        end else begin
            x = v;
            for (int k = 0; k < DIGITS; k++) begin
                r[4*k +: 4] = 4'(x % 10);
                x = x / 10;
            end
`ifdef BIN2BCD_BLANK_EN
            for (int k = DIGITS - 1; k >= 1; k--) begin
                if (r[4*k +: 4] != 4'd0) break;
                r[4*k +: 4] = 4'hF;
            end
`endif
        end
        return {ovf, r};
    endfunction

    // Pulses start for one edge, then counts edges until done (bounded).
    task automatic convert(input logic [WIDTH-1:0] v, input string tag);
        int lat;
        int busy_low;
        logic [24:0] exp;
        exp = model(v);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        #1;
        start    = 1'b0;
        bin      = WIDTH'($urandom);
        lat      = 0;
        busy_low = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_low++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, WIDTH + 1);
        check({tag, "_busy_low"}, busy_low, 0);
        check({tag, "_bcd"}, bcd, exp[23:0]);
        check({tag, "_ovf"}, overflow, exp[24]);
        check({tag, "_busy_at_done"}, busy, 1'b0);
    endtask

    initial begin
        logic [24:0] exp;
        int lat;
        int dones;

        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = ~start;
            bin   = WIDTH'($urandom);
        end
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bcd", bcd, 24'h000000);
        check("rst_ovf", overflow, 1'b0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        convert(20'd123456, "c123456");
        convert(20'd0,       "zero");
        convert(20'd999999,  "max_fit");
        convert(20'd1000000, "first_ovf");
        convert(20'hFFFFF,   "all_ones");
        convert(20'd507,     "v507");
        convert(20'd100000,  "v100000");
        convert(20'd9,       "v9");

        // done is a single-cycle pulse
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 1'b0);

        // Handshake: ignored start while busy, then start in the done cycle.
        @(negedge clk);
        start = 1'b1;
        bin   = 20'd42;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        lat   = 0;
        while (!done && lat < 100) begin
            if (lat == 4) begin
                start = 1'b1;
                bin   = 20'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check("hs_latency", lat, WIDTH + 1);
        exp = model(42);
        check("hs_bcd42", bcd, exp[23:0]);
        start = 1'b1;
        bin   = 20'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) dones++;
        end
        check("hs_second_gap", lat, WIDTH + 2);
        check("hs_single_done", dones, 1);
        exp = model(9);
        check("hs_bcd9", bcd, exp[23:0]);

        // Reset mid-conversion aborts with no done.
        @(negedge clk);
        start = 1'b1;
        bin   = 20'd654321;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_bcd", bcd, 24'h000000);
        check("mid_rst_ovf", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("mid_rst_no_done", dones, 0);
        convert(20'd1, "after_rst");

        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) convert(WIDTH'($urandom_range(0, 999999)), "rand_fit");
            else            convert(WIDTH'($urandom), "rand_full");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using iterative double-dabble (shift-and-add-3), one bit per clock. It sits directly upstream of the per-digit seven-segment decoders. It accepts an unsigned binary value on a start pulse and presents DIGITS packed BCD nibbles, each of which drives one decoder instance (6 HEX displays on DE10-Lite). Values that do not fit are saturated and flagged.

Parameters:
WIDTH, 20, bit width of binary input; 1..32
DIGITS, 6, number of BCD output digits; 1..9

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request; sampled only in IDLE
bin  input  WIDTH  unsigned binary value; captured on the accepted start edge
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; bcd/overflow updated in that same cycle
bcd  output  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0], digit k in [4k+3:4k]
overflow  output  1  last result exceeded 10^DIGITS-1

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE, busy=0, done=0, bcd=0 (all digits 4'h0), overflow=0. Internal shift/scratch/counter cleared. Reset mid-conversion aborts the conversion; outputs show the reset values, not partial results.
- States: IDLE, SHIFT, FINISH.
- IDLE: on rising edge with start=1: capture bin into shift register, clear BCD scratch, load counter=WIDTH, capture ovf_pending = (bin > 10^DIGITS-1), go to SHIFT, busy=1. start=0: remain in IDLE.
- SHIFT, one edge per input bit, MSB first: every scratch digit >=5 gets +3 (4-bit add, no carry across digits). Then {scratch, shift} shifts left by 1. The counter decrements. When counter reaches 1 on this edge, go to FINISH.
- Scratch holds DIGITS digits only; bits shifted out of the top are discarded.
- FINISH, one edge: bcd <= scratch, or all digits 4'h9 when ovf_pending. overflow <= ovf_pending. done=1 for exactly this next cycle; busy=0; go to IDLE.
- Latency: start accepted at edge N; busy high after edges N..N+WIDTH. At edge N+WIDTH+1: done=1, busy=0, outputs valid. Default = 21 edges.
- bcd and overflow hold their values until the next FINISH or reset.
- start while busy=1: ignored, no queuing.
- start in the done=1 cycle is accepted (state is IDLE), so back-to-back throughput is WIDTH+2 cycles per conversion.
- bin changes after capture have no effect.
- bin=0: all digits 0. WIDTH small enough that the maximum value always fits: overflow never asserts.
- Comparison constant 10^DIGITS-1 is computed at elaboration with enough width; no truncation.

Optional Feature:
BIN2BCD_BLANK_EN
- Defined: at FINISH, every zero digit above digit 0 that has no nonzero digit above it is output as 4'hF (blank code for the downstream decoder). Digit 0 is never blanked. The saturated overflow value is unaffected.
- Undefined: all digits are output as computed, with leading zeros shown.
- The reset value of bcd is all 4'h0 in both builds.

Test Plan:
- Reset: hold rst_n=0 with start toggling -> busy=0, done=0, bcd=24'h000000, overflow=0.
- Convert 123456: pulse start with bin=20'd123456 -> done pulse exactly 21 edges after start; bcd=24'h123456, overflow=0; busy high for the 20 intervening cycles.
- Boundaries: bin=0 -> 24'h000000 (blank build: 24'hFFFFF0). bin=999999 -> 24'h999999, overflow=0. bin=1000000 -> 24'h999999, overflow=1. bin=20'hFFFFF -> 24'h999999, overflow=1.
- Blanking (BIN2BCD_BLANK_EN): bin=507 -> 24'hFFF507. bin=100000 -> 24'h100000. Without the macro, bin=507 -> 24'h000507.
- Handshake: start with bin=42, then start with bin=7 at cycle 5 while busy -> single done, bcd=24'h000042. A third start in the done cycle with bin=9 -> second done 22 cycles after the first, bcd=24'h000009.
- Reset mid-conversion: assert rst_n=0 at cycle 10 of converting 654321 -> immediate reset values and no done. After release, conversion of 1 -> bcd=24'h000001.
